pulpemu_gpio_event: RTL and testbench
=====================================

Name: pulpemu_gpio_event

Overview:
- Input-side companion to the FPGA GPIO pad wrapper.
- Takes the raw pad input bits returned to PULP and resynchronises them into clk_i.
- Optionally debounces them, detects per-pin edge or level events and raises a sticky, write-1-to-clear interrupt.
- Sits between the pad IOBUF outputs and the PULP GPIO peripheral input/interrupt ports on the emulator top.

Parameters:
- NGPIO, 8, number of GPIO pins handled.
- SYNC_STAGES, 2, flop depth of the input synchroniser (min 2).
- DEBOUNCE_W, 8, width of debounce threshold and per-pin counters.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, synchronous, active-low.
- pad_in_i  in  NGPIO  raw asynchronous pad input values.
- in_en_i  in  NGPIO  1 = pin is an input (inverted PULP direction); events only when 1.
- int_en_i  in  NGPIO  per-pin interrupt enable.
- int_type_i  in  2*NGPIO  per-pin event type: 00 rising, 01 falling, 10 both edges, 11 level-high.
- debounce_cycles_i  in  DEBOUNCE_W  debounce threshold N (shared by all pins).
- irq_clr_i  in  NGPIO  write-1-to-clear pulse for irq_status_o bits.
- gpio_in_o  out  NGPIO  synchronised (and debounced) pin value.
- irq_status_o  out  NGPIO  sticky per-pin event flags.
- irq_o  out  1  registered OR of irq_status_o.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): all sync flops, stable values, counters, irq_status_o and irq_o go to 0. A pad held high through reset therefore produces a rising event after release.
- Synchroniser: SYNC_STAGES-deep flop chain per pin. Its last stage, sync[i], is the only consumer-visible sampled value.
- Stable register stable[i] drives gpio_in_o[i].
  - Without debounce: stable <= sync each cycle.
  - Pad change to gpio_in_o latency: SYNC_STAGES+1 edges (3 at default).
- Event detection uses stable_next vs stable, so the status bit sets on the same edge gpio_in_o changes.
  - rise = ~stable & stable_next.
  - fall = stable & ~stable_next.
  - level-high = stable_next.
- Status set condition: evt[i] & int_en_i[i] & in_en_i[i].
- Status update: irq_status[i] <= set[i] | (irq_status[i] & ~irq_clr_i[i]).
  - Simultaneous set and clear: set wins.
  - Level-high pins re-set every cycle while high, so a clear only takes effect once the pin is low.
- irq_o <= |irq_status_next, i.e. one register stage, asserting on the same edge as the status bit.
- Disabled pins: in_en_i=0 or int_en_i=0 blocks new status sets. gpio_in_o still tracks the pad for readback. Existing status bits stay until cleared.
- int_type_i change mid-operation: takes effect next edge, with no spurious event generated by the type change itself.

Optional Feature:
- Macro: PULPEMU_GPIO_DEBOUNCE_EN.
- Defined: a per-pin counter cnt[i] (DEBOUNCE_W bits) is instantiated.
  - Each edge with sync != stable: if cnt >= debounce_cycles_i then stable <= sync and cnt <= 0, else cnt++.
  - Each edge with sync == stable: cnt <= 0.
  - N=0 gives immediate update, identical to non-debounce timing.
  - N>0 adds N edges of latency; pulses shorter than N+1 cycles are rejected.
  - ">=" means that lowering N mid-count never wraps the counter.
  - The counter saturates at its maximum and never wraps.
- Undefined: no counters; debounce_cycles_i is ignored and stable follows sync directly.

Decomposition:
- Package pulpemu_gpio_pkg holds:
  - typedef enum logic [1:0] gpio_int_type_e {GPIO_RISE, GPIO_FALL, GPIO_BOTH, GPIO_LEVEL_HI};
  - localparam SYNC_STAGES_MIN = 2.
- Sub-module pulpemu_gpio_sync: single-bit SYNC_STAGES flop chain with the same clk_i/rst_ni, instantiated per pin via generate. All remaining logic stays in the top module.

Test Plan:
- Reset high pad: hold pad_in_i=8'hFF through reset, int_en_i=8'hFF, in_en_i=8'hFF, type rise, release reset.
  - Required: gpio_in_o=8'hFF and irq_status_o=8'hFF 3 edges later, irq_o=1 on that same edge.
- Falling edge and clear: pin 3, type fall. Drive the pad 1 then 0.
  - Required: irq_status_o[3] sets 3 edges after the fall.
  - Pulse irq_clr_i[3] for one cycle: the bit clears next edge, irq_o drops the same edge.
- Set beats clear (debounce off): type both, toggle pin 0 so the event coincides with irq_clr_i[0]=1.
  - Required: irq_status_o[0] stays 1.
- Level-high and masking:
  - Pin 5, type level, pad high, repeated clears: status stays 1.
  - Drive in_en_i[5]=0 and clear: status goes 0 while gpio_in_o[5] remains 1.
- Debounce (macro defined), debounce_cycles_i=4:
  - 4-cycle glitch on pin 1: gpio_in_o and status unchanged.
  - 5-cycle pulse: gpio_in_o[1] rises 7 edges after the pad change.
- Synchronous reset mid-count: assert rst_ni=0 while a debounce count is in progress.
  - Required: all outputs are 0 on the next edge.
  - After release, a stable high pad produces a full new debounce delay before it is reported.

Source files
------------

// File: rtl/pulpemu_gpio_pkg.sv
// Shared types and limits for the GPIO input event block.
package pulpemu_gpio_pkg;

  typedef enum logic [1:0] {
    GPIO_RISE     = 2'b00,
    GPIO_FALL     = 2'b01,
    GPIO_BOTH     = 2'b10,
    GPIO_LEVEL_HI = 2'b11
  } gpio_int_type_e;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/pulpemu_gpio_sync.sv
// Single-bit resynchroniser: STAGES-deep flop chain into clk_i.
module pulpemu_gpio_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/pulpemu_gpio_event.sv
// Pad input resync, optional debounce (PULPEMU_GPIO_DEBOUNCE_EN), per-pin event
// detection and sticky write-1-to-clear interrupt status.
module pulpemu_gpio_event
  import pulpemu_gpio_pkg::*;
#(
  parameter int NGPIO       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NGPIO-1:0]      pad_in_i,
  input  logic [NGPIO-1:0]      in_en_i,
  input  logic [NGPIO-1:0]      int_en_i,
  input  logic [2*NGPIO-1:0]    int_type_i,
  input  logic [DEBOUNCE_W-1:0] debounce_cycles_i,
  input  logic [NGPIO-1:0]      irq_clr_i,
  output logic [NGPIO-1:0]      gpio_in_o,
  output logic [NGPIO-1:0]      irq_status_o,
  output logic                  irq_o
);

  localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic [NGPIO-1:0] sync;
  logic [NGPIO-1:0] stable_q, stable_d;
  logic [NGPIO-1:0] irq_status_q, irq_status_d;
  logic [NGPIO-1:0] evt;
  logic             irq_q;

  for (genvar g = 0; g < NGPIO; g++) begin : g_sync
    pulpemu_gpio_sync #(
      .STAGES(STAGES)
    ) u_sync (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (pad_in_i[g]),
      .q_o   (sync[g])
    );
  end

`ifdef PULPEMU_GPIO_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] cnt_q [NGPIO];
  logic [DEBOUNCE_W-1:0] cnt_d [NGPIO];

  // ">=" lets a lowered threshold release a running count instead of wrapping
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NGPIO; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != stable_q[i]) begin
        if (cnt_q[i] >= debounce_cycles_i) begin
          stable_d[i] = sync[i];
        end else if (cnt_q[i] != '1) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NGPIO; i++) begin
      if (!rst_ni) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  logic unused_debounce;
  assign unused_debounce = ^debounce_cycles_i;
  assign stable_d        = sync;
`endif

  always_comb begin
    evt = '0;
    for (int i = 0; i < NGPIO; i++) begin
      case (gpio_int_type_e'(int_type_i[2*i +: 2]))
        GPIO_RISE:     evt[i] = ~stable_q[i] &  stable_d[i];
        GPIO_FALL:     evt[i] =  stable_q[i] & ~stable_d[i];
        GPIO_BOTH:     evt[i] =  stable_q[i] ^  stable_d[i];
        GPIO_LEVEL_HI: evt[i] =  stable_d[i];
      endcase
    end
  end

  // A new event in the same cycle as a clear keeps the bit set
  assign irq_status_d = (evt & int_en_i & in_en_i) | (irq_status_q & ~irq_clr_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stable_q     <= '0;
      irq_status_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      stable_q     <= stable_d;
      irq_status_q <= irq_status_d;
      irq_q        <= |irq_status_d;
    end
  end

  assign gpio_in_o    = stable_q;
  assign irq_status_o = irq_status_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_pulpemu_gpio_event.sv
// Scoreboard bench for pulpemu_gpio_event: expectations are queued with their
// due edge when stimulus is applied and compared on the falling clock edge.
module tb_pulpemu_gpio_event;

`ifdef PULPEMU_GPIO_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pad, in_en, int_en, clr, dbc;
  logic [15:0] itype;
  logic [7:0]  gpio, status;
  logic        irq;

  pulpemu_gpio_event #(
    .NGPIO(8), .SYNC_STAGES(2), .DEBOUNCE_W(8)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pad_in_i         (pad),
    .in_en_i          (in_en),
    .int_en_i         (int_en),
    .int_type_i       (itype),
    .debounce_cycles_i(dbc),
    .irq_clr_i        (clr),
    .gpio_in_o        (gpio),
    .irq_status_o     (status),
    .irq_o            (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // sel: 0 gpio_in_o, 1 irq_status_o, 2 irq_o
  task automatic expect_at(input int dly, input int sel, input logic [7:0] v, input string tag);
    exp_t e;
    e.due = cyc + dly;
    e.sel = sel;
    e.exp = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].sel)
          0:       check(sb[i].tag, gpio, sb[i].exp);
          1:       check(sb[i].tag, status, sb[i].exp);
          default: check(sb[i].tag, {7'b0, irq}, sb[i].exp);
        endcase
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout edge=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; pad = 8'hFF; in_en = 8'hFF; int_en = 8'hFF;
    itype = 16'h0000; clr = 8'h00; dbc = 8'h00;
    tick(1);
    expect_at(1, 0, 8'h00, "rst_gpio");
    expect_at(1, 1, 8'h00, "rst_stat");
    expect_at(1, 2, 8'h00, "rst_irq");
    tick(2);

    // pad held high through reset reports a rising event after release
    rst_n = 1'b1;
    expect_at(2, 0, 8'h00, "rel_gpio_early");
    expect_at(2, 2, 8'h00, "rel_irq_early");
    expect_at(3, 0, 8'hFF, "rel_gpio");
    expect_at(3, 1, 8'hFF, "rel_stat");
    expect_at(3, 2, 8'h01, "rel_irq");
    tick(4);
    clr = 8'hFF;
    expect_at(1, 1, 8'h00, "clr_all");
    expect_at(1, 2, 8'h00, "clr_irq");
    tick(1);
    clr = 8'h00;

    // falling edge on pin 3 and its clear
    int_en = 8'h08; itype = 16'h0040; pad[3] = 1'b0;
    expect_at(2, 1, 8'h00, "fall_early");
    expect_at(3, 1, 8'h08, "fall_stat");
    expect_at(3, 2, 8'h01, "fall_irq");
    expect_at(3, 0, 8'hF7, "fall_gpio");
    tick(4);
    clr = 8'h08;
    expect_at(1, 1, 8'h00, "fall_clr");
    expect_at(1, 2, 8'h00, "fall_clr_irq");
    tick(1);
    clr = 8'h00;

    // event and clear on the same edge: the set wins
    int_en = 8'h01; itype = 16'h0002; pad[0] = 1'b0;
    tick(2);
    clr = 8'h01;
    expect_at(1, 1, 8'h01, "setwin_stat");
    expect_at(1, 2, 8'h01, "setwin_irq");
    tick(1);
    clr = 8'h00;
    expect_at(1, 1, 8'h01, "setwin_hold");
    tick(1);
    clr = 8'h01;
    expect_at(1, 1, 8'h00, "setwin_clr");
    tick(1);
    clr = 8'h00;

    // interrupt disabled: readback follows the pad, no status
    int_en = 8'h00; pad[3] = 1'b1;
    expect_at(3, 0, 8'hFE, "mask_gpio");
    expect_at(3, 1, 8'h00, "mask_stat");
    tick(4);

    // type changes on a steady-high pin raise nothing
    int_en = 8'h04; itype = 16'h0000;
    tick(1);
    itype = 16'h0010;
    tick(1);
    itype = 16'h0020;
    expect_at(1, 1, 8'h00, "type_chg1");
    expect_at(2, 1, 8'h00, "type_chg2");
    tick(2);

    // level-high on pin 5 survives clears until the pin is masked
    int_en = 8'h20; itype = 16'h0C00;
    expect_at(1, 1, 8'h20, "lvl_set");
    tick(1);
    clr = 8'h20;
    expect_at(1, 1, 8'h20, "lvl_clr1");
    expect_at(2, 1, 8'h20, "lvl_clr2");
    expect_at(2, 2, 8'h01, "lvl_irq");
    tick(2);
    in_en = 8'hDF;
    expect_at(1, 1, 8'h00, "lvl_mask");
    expect_at(1, 0, 8'hFE, "lvl_gpio");
    expect_at(1, 2, 8'h00, "lvl_irq_off");
    tick(1);
    clr = 8'h00; in_en = 8'hFF; int_en = 8'h00; itype = 16'h0000;
    tick(1);

`ifdef PULPEMU_GPIO_DEBOUNCE_EN
    dbc = 8'd4; int_en = 8'h02; itype = 16'h0008;
    tick(1);
    pad[1] = 1'b0;
    expect_at(3, 0, 8'hFE, "db_glitch_a");
    expect_at(7, 0, 8'hFE, "db_glitch_b");
    expect_at(9, 0, 8'hFE, "db_glitch_c");
    expect_at(9, 1, 8'h00, "db_glitch_stat");
    tick(4);
    pad[1] = 1'b1;
    tick(6);
    pad[1] = 1'b0;
    expect_at(6, 0, 8'hFE, "db_pre");
    expect_at(7, 0, 8'hFC, "db_fall");
    expect_at(7, 1, 8'h02, "db_stat");
    expect_at(7, 2, 8'h01, "db_irq");
    tick(5);
    pad[1] = 1'b1;
    expect_at(6, 0, 8'hFC, "db_ret_pre");
    expect_at(7, 0, 8'hFE, "db_ret");
    tick(8);
    clr = 8'h02;
    expect_at(1, 1, 8'h00, "db_clr");
    tick(1);
    clr = 8'h00; int_en = 8'h00; itype = 16'h0000;
    tick(1);
`endif

    // reset while pin 1 is mid-change (mid-count when debouncing)
    dbc = 8'(DB);
    pad[1] = 1'b0;
    tick(5);
    rst_n = 1'b0;
    expect_at(1, 0, 8'h00, "rst2_gpio0");
    expect_at(1, 1, 8'h00, "rst2_stat0");
    expect_at(1, 2, 8'h00, "rst2_irq0");
    tick(2);
    int_en = 8'hFF; itype = 16'h0000;
    rst_n = 1'b1;
    expect_at(2 + DB, 0, 8'h00, "rst2_early");
    expect_at(3 + DB, 0, 8'hFC, "rst2_gpio");
    expect_at(3 + DB, 1, 8'hFC, "rst2_stat");
    expect_at(3 + DB, 2, 8'h01, "rst2_irq");
    tick(4 + DB);

    tick(2);
    foreach (sb[i]) begin
      bad++;
      $display("FAIL %s never checked (due edge %0d)", sb[i].tag, sb[i].due);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
